// File: rtl/usf_recovery_ctrl_if.sv
// usf_recovery_ctrl_if
//   Bundles every non-clock signal of the USF recovery controller.
//   The three groups are the folded-sample input, the recovery-core
//   frame/start/result bus, and the recovered-sample stream.
//
//   Modports
//     slave  : the controller. It consumes samples, core results and
//              rec_ready. It drives frame_out, core_en, the stream and
//              the status bits.
//     master : the environment (ADC front end, recovery core and stream
//              sink). It has the opposite directions.
//
//   Parameters must match the controller instance:
//   N_SAMPLES, IN_W and OUT_W.
//
//   sample_in is a two's-complement IN_W-bit value. The controller
//   stores it bit-for-bit, so it is declared as a plain vector.

interface usf_recovery_ctrl_if #(
  parameter int N_SAMPLES = 13,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16
);
  logic [IN_W-1:0]                  sample_in;
  logic                             sample_valid;
  logic [N_SAMPLES-1:0][IN_W-1:0]   frame_out;
  logic                             core_en;
  logic [N_SAMPLES-1:0][OUT_W-1:0]  core_out;
  logic [OUT_W-1:0]                 rec_data;
  logic                             rec_valid;
  logic                             rec_ready;
  logic                             rec_last;
  logic                             busy;
  logic                             overflow;

  modport slave (
    input  sample_in, sample_valid, core_out, rec_ready,
    output frame_out, core_en, rec_data, rec_valid, rec_last, busy, overflow
  );

  modport master (
    output sample_in, sample_valid, core_out, rec_ready,
    input  frame_out, core_en, rec_data, rec_valid, rec_last, busy, overflow
  );
endinterface

// File: rtl/usf_recovery_ctrl.sv
// usf_recovery_ctrl
//   Sequences an unlimited-sampling (USF) recovery core.
//   - Collects N_SAMPLES folded ADC samples into an input frame.
//   - Pulses core_en once.
//   - Waits CORE_LAT cycles, then captures the core's recovered frame.
//   - Streams that frame out one sample at a time on a valid/ready
//     handshake, with rec_last marking the final sample.
//
//   Ports
//     clk    : single rising-edge clock
//     reset  : synchronous, active-high; overrides every other event
//     bus    : usf_recovery_ctrl_if.slave
//              sample_in/sample_valid   folded sample input (no backpressure)
//              frame_out/core_en        frame and start pulse to the core
//              core_out                 recovered frame from the core
//              rec_data/rec_valid/rec_ready/rec_last   output stream
//              busy                     state is not FILL
//              overflow                 sticky, an input sample was dropped
//
//   Build option
//     USF_CTRL_PINGPONG_EN
//       When defined, two input banks are used. Samples arriving while
//       busy fill the idle bank. A full idle bank is fired straight out
//       of DRAIN.
//       When undefined, there is a single bank. Samples arriving while
//       busy are dropped and set overflow.
//     The port list is identical in both builds.

module usf_recovery_ctrl #(
  parameter int N_SAMPLES = 13,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16,
  parameter int CORE_LAT  = 4
) (
  input logic               clk,
  input logic               reset,
  usf_recovery_ctrl_if.slave bus
);

  localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int LAT_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] FIRE  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]                      state;
  logic [IDX_W-1:0]                wr_idx;
  logic [IDX_W-1:0]                rd_idx;
  logic [LAT_W-1:0]                lat_cnt;
  logic [N_SAMPLES-1:0][OUT_W-1:0] outbuf;
  logic                            overflow;

  logic fill_last;
  logic handshake;
  logic refire;

  assign fill_last = bus.sample_valid && (state == FILL) && (wr_idx == LAST_IDX);
  assign handshake = (state == DRAIN) && bus.rec_ready;

`ifdef USF_CTRL_PINGPONG_EN
  // bank[act_bank] is the frame currently being filled (in FILL) or
  // processed (in FIRE/WAIT/DRAIN). The other bank soaks up samples that
  // arrive while busy. wr_idx is shared because only one bank is ever
  // being written at a time.
  logic [1:0][N_SAMPLES-1:0][IN_W-1:0] bank;
  logic act_bank;
  logic idle_full;
  logic fill_wr;
  logic idle_wr;
  logic idle_wr_last;
  logic drain_done;

  assign fill_wr      = bus.sample_valid && (state == FILL);
  assign idle_wr      = bus.sample_valid && (state != FILL) && !idle_full;
  assign idle_wr_last = idle_wr && (wr_idx == LAST_IDX);
  assign drain_done   = handshake && (rd_idx == LAST_IDX);

  // The idle bank may complete in the same cycle the last sample drains,
  // so refire also looks at this cycle's write.
  assign refire = idle_full || idle_wr_last;

  assign bus.frame_out = bank[act_bank];

  // Input banks, shared write index and overflow.
  // On drain completion the banks swap roles. A partially filled idle
  // bank simply becomes the active bank and FILL continues at wr_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank      <= '0;
      act_bank  <= 1'b0;
      idle_full <= 1'b0;
      wr_idx    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (fill_wr) begin
        bank[act_bank][wr_idx] <= bus.sample_in;
      end
      if (idle_wr) begin
        bank[~act_bank][wr_idx] <= bus.sample_in;
      end
      if (fill_wr || idle_wr) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
      end
      if (drain_done) begin
        act_bank  <= ~act_bank;
        idle_full <= 1'b0;
      end else if (idle_wr_last) begin
        idle_full <= 1'b1;
      end
      if (bus.sample_valid && (state != FILL) && idle_full) begin
        overflow <= 1'b1;
      end
    end
  end
`else
  logic [N_SAMPLES-1:0][IN_W-1:0] inbuf;

  assign refire        = 1'b0;
  assign bus.frame_out = inbuf;

  // Single input bank. It is written only in FILL, so it stays frozen
  // while the core reads it. Anything arriving while busy is lost and
  // flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      inbuf    <= '0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.sample_valid && (state == FILL)) begin
        inbuf[wr_idx] <= bus.sample_in;
        wr_idx        <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
      end
      if (bus.sample_valid && (state != FILL)) begin
        overflow <= 1'b1;
      end
    end
  end
`endif

  // Sequencing FSM.
  // lat_cnt is loaded in FIRE with CORE_LAT-1 and counts down in WAIT.
  // The capture cycle (lat_cnt == 0) is therefore exactly CORE_LAT cycles
  // after the core_en cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      rd_idx  <= '0;
      lat_cnt <= '0;
      outbuf  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (fill_last) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            outbuf <= bus.core_out;
            state  <= DRAIN;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              state  <= refire ? FIRE : FILL;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Outputs are decoded from registered state only. This keeps rec_data
  // and rec_last stable while the sink stalls.
  assign bus.core_en   = (state == FIRE);
  assign bus.rec_valid = (state == DRAIN);
  assign bus.rec_data  = outbuf[rd_idx];
  assign bus.rec_last  = (state == DRAIN) && (rd_idx == LAST_IDX);
  assign bus.busy      = (state != FILL);
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_usf_recovery_ctrl.sv
// tb_usf_recovery_ctrl
//   Directed and randomized bench for usf_recovery_ctrl (default build,
//   USF_CTRL_PINGPONG_EN undefined).
//
//   The reference model is a frame-level abstraction:
//   - a frame is N accepted samples;
//   - the controller is busy from the 13th accepted sample until the
//     13th handshake;
//   - core_en is due one cycle after the 13th sample;
//   - the stream is due CORE_LAT+1 cycles after core_en;
//   - any sample seen while busy is dropped and latches overflow.
//
//   A small recovery-core emulator drives random junk on core_out, except
//   in exactly the cycle CORE_LAT after core_en. In that cycle it drives
//   the real result, computed from the frame_out it observes.

module tb_usf_recovery_ctrl;

  localparam int N     = 13;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  usf_recovery_ctrl_if #(.N_SAMPLES(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  usf_recovery_ctrl #(
    .N_SAMPLES(N), .IN_W(IN_W), .OUT_W(OUT_W), .CORE_LAT(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  logic [IN_W-1:0]  mframe [N];
  logic [OUT_W-1:0] mexp   [N];
  int               mcnt     = 0;
  int               mhs      = 0;
  bit               mbusy    = 1'b0;
  bit               movf     = 1'b0;
  int               fire_cyc = -1000;
  int               core_mode = 0;
  int               core_cnt  = 0;
  int               dut_hs    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle:
  //   1. drive the inputs #1 after the rising edge;
  //   2. emulate the core;
  //   3. compare every output against the model;
  //   4. advance the model by what the DUT will see at the next edge.
  task automatic applyStimulus(input bit rst, input bit sv, input logic [IN_W-1:0] smp, input bit rdy);
    bit exp_valid;
    int v;
    @(posedge clk);
    #1;
    cyc++;
    reset            = rst;
    bus.sample_valid = sv;
    bus.sample_in    = smp;
    bus.rec_ready    = rdy;

    if (core_cnt > 0) begin
      core_cnt--;
      for (int k = 0; k < N; k++) begin
        if (core_cnt != 0) begin
          bus.core_out[k] = OUT_W'($urandom);
        end else if (core_mode == 0) begin
          bus.core_out[k] = OUT_W'(k * 100);
        end else begin
          v = $signed(bus.frame_out[k]);
          bus.core_out[k] = OUT_W'(v * 4 + k);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) bus.core_out[k] = OUT_W'($urandom);
    end
    if (bus.core_en === 1'b1) core_cnt = LAT;

    exp_valid = mbusy && (cyc >= fire_cyc + LAT + 1);
    checkOutput("core_en",   bus.core_en,   (cyc == fire_cyc));
    checkOutput("rec_valid", bus.rec_valid, exp_valid);
    checkOutput("busy",      bus.busy,      mbusy);
    checkOutput("overflow",  bus.overflow,  movf);
    if (exp_valid) begin
      checkOutput("rec_data", bus.rec_data, mexp[mhs]);
      checkOutput("rec_last", bus.rec_last, (mhs == N - 1));
    end else begin
      checkOutput("rec_last_idle", bus.rec_last, 1'b0);
    end
    if (cyc == fire_cyc) begin
      for (int k = 0; k < N; k++) checkOutput("frame_out", bus.frame_out[k], mframe[k]);
    end
    if (bus.rec_valid === 1'b1 && rdy) dut_hs++;

    if (rst) begin
      mbusy    = 1'b0;
      movf     = 1'b0;
      mcnt     = 0;
      mhs      = 0;
      fire_cyc = -1000;
      core_cnt = 0;
    end else begin
      // Sample first, against the pre-cycle busy flag.
      if (sv) begin
        if (mbusy) begin
          movf = 1'b1;
        end else begin
          mframe[mcnt] = smp;
          mcnt++;
          if (mcnt == N) begin
            mcnt     = 0;
            mbusy    = 1'b1;
            fire_cyc = cyc + 1;
            for (int k = 0; k < N; k++) begin
              if (core_mode == 0) begin
                mexp[k] = OUT_W'(k * 100);
              end else begin
                v = $signed(mframe[k]);
                mexp[k] = OUT_W'(v * 4 + k);
              end
            end
          end
        end
      end
      if (exp_valid && rdy) begin
        mhs++;
        if (mhs == N) begin
          mhs   = 0;
          mbusy = 1'b0;
        end
      end
    end
  endtask

  // Run idle cycles until the model's frame has fully drained.
  // Pattern 0 keeps rec_ready high. Pattern 1 raises it 1 cycle in 4.
  task automatic runDrain(input int pattern);
    int i;
    i = 0;
    while (mbusy && i < 400) begin
      applyStimulus(1'b0, 1'b0, '0, (pattern == 0) ? 1'b1 : ((i % 4) == 3));
      i++;
    end
  endtask

  task automatic sendFrame();
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b1, IN_W'($urandom), 1'b1);
  endtask

  int vals [N] = '{1, 8, 19, 25, 10, 1, 9, 13, 20, 23, 30, 10, 10};

  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.rec_ready    = 1'b0;
    bus.core_out     = '0;

    // Reset with a sample present: reset must win.
    applyStimulus(1'b1, 1'b1, 12'h5, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("rst_rec_data", bus.rec_data, '0);
    checkOutput("rst_rec_last", bus.rec_last, 1'b0);
    checkOutput("rst_frame0",   bus.frame_out[0], '0);

    // Fixed frame, one sample per 50 cycles, core returns k*100.
    $display("[TB] fixed frame and latency");
    core_mode = 0;
    dut_hs    = 0;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, IN_W'(vals[i]), 1'b1);
      if (i < N - 1) begin
        for (int j = 0; j < 49; j++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      end
    end
    runDrain(0);
    checkOutput("hs_count_fixed", dut_hs, N);

    // Backpressure with random samples and a core result derived from the frame.
    $display("[TB] backpressure");
    core_mode = 1;
    dut_hs    = 0;
    sendFrame();
    runDrain(1);
    checkOutput("hs_count_bp", dut_hs, N);

    // Sample during WAIT is dropped; overflow is sticky; next frame is clean.
    $display("[TB] overflow");
    sendFrame();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, IN_W'($urandom), 1'b1);
    runDrain(0);
    dut_hs = 0;
    sendFrame();
    runDrain(0);
    checkOutput("hs_count_after_ovf", dut_hs, N);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("overflow_sticky", bus.overflow, 1'b1);

    // Reset in DRAIN after 5 handshakes, together with a sample and a handshake.
    $display("[TB] reset in drain");
    sendFrame();
    while (!(mbusy && mhs == 5)) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, IN_W'($urandom), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("rst_drain_valid", bus.rec_valid, 1'b0);
    checkOutput("rst_drain_busy",  bus.busy,      1'b0);
    checkOutput("rst_drain_ovf",   bus.overflow,  1'b0);
    checkOutput("rst_drain_data",  bus.rec_data,  '0);
    for (int i = 0; i < N - 1; i++) begin
      applyStimulus(1'b0, 1'b1, IN_W'($urandom), 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
    end
    for (int j = 0; j < 20; j++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    dut_hs = 0;
    applyStimulus(1'b0, 1'b1, IN_W'($urandom), 1'b1);
    runDrain(0);
    checkOutput("hs_count_after_rst", dut_hs, N);

    // Random traffic, random backpressure and rare resets.
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)),
                    IN_W'($urandom), ($urandom_range(0, 2) != 0));
    end
    runDrain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
